mac_array: RTL and testbench

Parametrised multi-lane successor of the single-lane MAC core: LANES independent signed multiply-accumulate lanes compute one dot product per lane over a programmable vector length, with a valid/ready stream on the input and a held, valid/ready result on the output. It sits between the activation/weight feeders and the post-processing (bias/activation) stage of the datapath, consuming one element per lane per accepted beat.

---
 rtl/mac_array_pkg.sv | 28 ++
 rtl/mac_array_lane.sv | 111 +++++++++++
 rtl/mac_array.sv | 139 +++++++++++++
 tb/tb_mac_array.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mac_array_pkg.sv
// Shared types and helpers for mac_array: FSM state encoding and the
// saturation limits used when MAC_ARRAY_SAT_EN is defined.
package mac_array_pkg;

    localparam int STATE_W     = 2;
    localparam int SAT_LIMIT_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Most positive / most negative two's-complement value of acc_width bits,
    // returned sign-extended to SAT_LIMIT_W so callers can slice what they need.
    function automatic logic [SAT_LIMIT_W-1:0] sat_limit(input int unsigned acc_width,
                                                          input logic        negative);
        logic [SAT_LIMIT_W-1:0] lim;
        if (negative) begin
            lim = {SAT_LIMIT_W{1'b1}} << (acc_width - 32'd1);
        end else begin
            lim = ({{(SAT_LIMIT_W-1){1'b0}}, 1'b1} << (acc_width - 32'd1)) - 64'd1;
        end
        return lim;
    endfunction

endpackage

// File: rtl/mac_array_lane.sv
// One signed MAC lane: registered product, then load/accumulate stage.
// Saturating accumulate with sticky flag when MAC_ARRAY_SAT_EN is defined.
module mac_array_lane
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_fire,
    input  logic                    in_first,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    output logic [ACCUM_WIDTH-1:0]  acc,
    output logic                    sat
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [PROD_WIDTH-1:0]  prod_d, prod_q;
    logic                          s1_valid_d, s1_valid_q;
    logic                          s1_first_d, s1_first_q;
    logic signed [ACCUM_WIDTH-1:0] prod_ext_s;
    logic signed [ACCUM_WIDTH-1:0] acc_d, acc_q;

    // Stage 1: capture the signed product and its tags on an accepted beat.
    always_comb begin
        s1_valid_d = in_fire;
        if (in_fire) begin
            prod_d     = PROD_WIDTH'($signed(in_data)) * PROD_WIDTH'($signed(in_weight));
            s1_first_d = in_first;
        end else begin
            prod_d     = prod_q;
            s1_first_d = s1_first_q;
        end
    end

`ifdef MAC_ARRAY_SAT_EN
    localparam logic [SAT_LIMIT_W-1:0] SAT_MAX_W = sat_limit(ACCUM_WIDTH, 1'b0);
    localparam logic [SAT_LIMIT_W-1:0] SAT_MIN_W = sat_limit(ACCUM_WIDTH, 1'b1);
    localparam logic [ACCUM_WIDTH-1:0] SAT_MAX   = SAT_MAX_W[ACCUM_WIDTH-1:0];
    localparam logic [ACCUM_WIDTH-1:0] SAT_MIN   = SAT_MIN_W[ACCUM_WIDTH-1:0];

    logic [ACCUM_WIDTH:0] sum_g_s;
    logic                 sat_d, sat_q;

    // Stage 2: load or add with one guard bit, clamping on signed overflow.
    always_comb begin
        prod_ext_s = ACCUM_WIDTH'(prod_q);
        sum_g_s    = {acc_q[ACCUM_WIDTH-1], acc_q} + {prod_ext_s[ACCUM_WIDTH-1], prod_ext_s};
        if (!s1_valid_q) begin
            acc_d = acc_q;
            sat_d = sat_q;
        end else if (s1_first_q) begin
            acc_d = prod_ext_s;
            sat_d = 1'b0;
        end else if (sum_g_s[ACCUM_WIDTH] != sum_g_s[ACCUM_WIDTH-1]) begin
            acc_d = sum_g_s[ACCUM_WIDTH] ? SAT_MIN : SAT_MAX;
            sat_d = 1'b1;
        end else begin
            acc_d = sum_g_s[ACCUM_WIDTH-1:0];
            sat_d = sat_q;
        end
    end

    // Sticky saturation flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    // Stage 2: load or add, wrapping modulo 2^ACCUM_WIDTH.
    always_comb begin
        prod_ext_s = ACCUM_WIDTH'(prod_q);
        if (!s1_valid_q) begin
            acc_d = acc_q;
        end else if (s1_first_q) begin
            acc_d = prod_ext_s;
        end else begin
            acc_d = acc_q + prod_ext_s;
        end
    end

    assign sat = 1'b0;
`endif

    // Pipeline and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= {PROD_WIDTH{1'b0}};
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            acc_q      <= {ACCUM_WIDTH{1'b0}};
        end else begin
            prod_q     <= prod_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            acc_q      <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_array.sv
// LANES-wide signed dot-product engine with valid/ready in and held result out.
// Optional saturation: define MAC_ARRAY_SAT_EN.
module mac_array
    import mac_array_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32,
    parameter int LANES        = 4,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LEN_WIDTH-1:0]          cfg_len_m1,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [LANES*WEIGHT_WIDTH-1:0] in_weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACCUM_WIDTH-1:0]  out_accum,
    output logic [LANES-1:0]              out_sat
);

    state_e               state_d, state_q;
    logic [LEN_WIDTH-1:0] len_d, len_q;
    logic [LEN_WIDTH-1:0] cnt_d, cnt_q;
    logic                 s1_last_d, s1_last_q;
    logic                 in_ready_d, in_ready_q;
    logic                 out_valid_d, out_valid_q;
    logic                 in_fire_s;
    logic                 first_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, vector length latch and element counter (cnt = index of next beat).
    always_comb begin
        in_fire_s = in_valid && in_ready_q;
        first_s   = (state_q == ST_IDLE);
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        s1_last_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) begin
                    len_d     = cfg_len_m1;
                    cnt_d     = LEN_WIDTH'(1);
                    s1_last_d = (cfg_len_m1 == {LEN_WIDTH{1'b0}});
                    state_d   = s1_last_d ? ST_DRAIN : ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_fire_s) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (cnt_q == len_q) begin
                        s1_last_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            // The last product sits in stage 1 now; the accumulator takes it this edge.
            ST_DRAIN: begin
                if (s1_last_q) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the handshake outputs are registered.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
    end

    // Control and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= {LEN_WIDTH{1'b0}};
            cnt_q       <= {LEN_WIDTH{1'b0}};
            s1_last_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            s1_last_q   <= s1_last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_array_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ACCUM_WIDTH (ACCUM_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_fire  (in_fire_s),
            .in_first (first_s),
            .in_data  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .in_weight(in_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .acc      (out_accum[g*ACCUM_WIDTH +: ACCUM_WIDTH]),
            .sat      (out_sat[g])
        );
    end

endmodule

// File: tb/tb_mac_array.sv
// Directed, table-driven bench for mac_array (32-bit and 24-bit accumulator builds).
module tb_mac_array;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int WW    = 8;
    localparam int LW    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LW-1:0]         cfg_len_m1;
    logic                  in_valid;
    logic                  in_ready, in_ready24;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES*WW-1:0]   in_weight;
    logic                  out_valid, out_valid24;
    logic                  out_ready;
    logic [LANES*32-1:0]   out_accum;
    logic [LANES*24-1:0]   out_accum24;
    logic [LANES-1:0]      out_sat, out_sat24;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_array #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(32), .LANES(LANES), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .cfg_len_m1(cfg_len_m1), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid), .out_ready(out_ready),
        .out_accum(out_accum), .out_sat(out_sat));

    mac_array #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(24), .LANES(LANES), .LEN_WIDTH(LW)) dut24 (
        .clk(clk), .rst(rst), .cfg_len_m1(cfg_len_m1), .in_valid(in_valid), .in_ready(in_ready24),
        .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid24), .out_ready(out_ready),
        .out_accum(out_accum24), .out_sat(out_sat24));

    typedef struct {
        string                name;
        logic [LW-1:0]        len_m1;
        logic [LANES*DW-1:0]  data;
        logic [LANES*WW-1:0]  weight;
        logic [LANES*32-1:0]  exp;
        bit                   gap;
        bit                   early;
        bit                   sat_case;
        int                   hold;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input string name, input logic [LW-1:0] len_m1,
                                input logic [LANES*DW-1:0] data, input logic [LANES*WW-1:0] weight,
                                input logic [LANES*32-1:0] exp, input bit gap, input bit early,
                                input bit sat_case, input int hold);
        vec_t v;
        v.name = name; v.len_m1 = len_m1; v.data = data; v.weight = weight; v.exp = exp;
        v.gap = gap; v.early = early; v.sat_case = sat_case; v.hold = hold;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) step();
        chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_vector(input vec_t v);
        logic [LANES*24-1:0] exp24;
        logic [LANES-1:0]    sat24;
        out_ready  = v.early;
        cfg_len_m1 = v.len_m1;
        in_data    = v.data;
        in_weight  = v.weight;
        for (int b = 0; b <= int'(v.len_m1); b++) begin
            if (v.gap && b > 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            wait_ready(v.name);
            step();
            if (b == 0) cfg_len_m1 = ~v.len_m1;
        end
        in_valid = 1'b0;
        chk({v.name, "_valid_n1"}, 128'(out_valid), 128'd0);
        chk({v.name, "_ready_drain"}, 128'(in_ready), 128'd0);
        step();
        chk({v.name, "_valid_n2"}, 128'(out_valid), 128'd1);
        for (int i = 0; i < LANES; i++) exp24[i*24 +: 24] = v.exp[i*32 +: 24];
        sat24 = 4'h0;
        if (v.sat_case) begin
`ifdef MAC_ARRAY_SAT_EN
            exp24 = {4{24'h800000}};
            sat24 = 4'hF;
`else
            exp24 = {4{24'h400180}};
`endif
        end
        chk({v.name, "_accum32"}, 128'(out_accum), 128'(v.exp));
        chk({v.name, "_sat32"}, 128'(out_sat), 128'd0);
        chk({v.name, "_accum24"}, 128'(out_accum24), 128'(exp24));
        chk({v.name, "_sat24"}, 128'(out_sat24), 128'(sat24));
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_data  = {4{16'h1234}};
            step();
            chk({v.name, "_hold_valid"}, 128'(out_valid), 128'd1);
            chk({v.name, "_hold_accum"}, 128'(out_accum), 128'(v.exp));
            chk({v.name, "_hold_ready"}, 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({v.name, "_valid_after_hs"}, 128'(out_valid), 128'd0);
        chk({v.name, "_ready_after_hs"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk("len4_basic", 8'd3, {4{16'h0400}}, {4{8'h40}}, {4{32'h00040000}}, 1'b0, 1'b0, 1'b0, 0);
        vecs[1] = mk("len1_lanes", 8'd0, {16'h8000, 16'h7FFF, 16'hFC00, 16'h0400}, {8'h80, 8'h7F, 8'hC0, 8'hC0},
                     {32'h00400000, 32'h003F7F81, 32'h00010000, 32'hFFFF0000}, 1'b0, 1'b1, 1'b0, 0);
        vecs[2] = mk("len8_gaps", 8'd7, {4{16'h0400}}, {4{8'h40}}, {4{32'h00080000}}, 1'b1, 1'b0, 1'b0, 0);
        vecs[3] = mk("len2_backpr", 8'd1, {16'h0000, 16'h0100, 16'hFFFF, 16'h0010}, {8'h55, 8'hFF, 8'h01, 8'h03},
                     {32'h00000000, 32'hFFFFFE00, 32'hFFFFFFFE, 32'h00000060}, 1'b0, 1'b0, 1'b0, 10);
        vecs[4] = mk("len3_sat", 8'd2, {4{16'h7FFF}}, {4{8'h80}}, {4{32'hFF400180}}, 1'b0, 1'b0, 1'b1, 0);

        rst = 1'b1; cfg_len_m1 = 8'd0; in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_accum", 128'(out_accum), 128'd0);
        chk("rst_out_sat", 128'(out_sat), 128'd0);
        chk("rst_out_accum24", 128'(out_accum24), 128'd0);
        rst = 1'b0;
        chk("rel_in_ready_pre", 128'(in_ready), 128'd0);
        step();
        chk("rel_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 5; i++) run_vector(vecs[i]);

        // Reset after two of four beats: nothing emitted, next vector clean.
        cfg_len_m1 = 8'd3;
        in_data    = {4{16'h7FFF}};
        in_weight  = {4{8'h7F}};
        in_valid   = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_accum", 128'(out_accum), 128'd0);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_valid", 128'(out_valid), 128'd0);
            step();
        end
        run_vector(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
